// File: rtl/pixel_sensor_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_sensor_controller_pkg
//  Description : Shared configuration for the pixel sensor frame sequencer.
//                Holds the pixel array geometry, the default phase lengths,
//                the controller state encoding and a small sizing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pixel_sensor_controller_pkg;

    // Pixel array geometry
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_ARRAY_WIDTH  = 2;
    localparam int PIXEL_BITS         = 8;

    // Default phase lengths, in clock cycles
    localparam int C_ERASE_DEF    = 5;
    localparam int C_EXPOSE_DEF   = 255;
    localparam int C_CONVERT_DEF  = 255;
    localparam int C_READ_ROW_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ERASE    = 3'd1,
        ST_EXPOSE   = 3'd2,
        ST_CONVERT  = 3'd3,
        ST_READ_ROW = 3'd4,
        ST_ROW_WAIT = 3'd5,
        ST_GAP      = 3'd6
    } pixel_ctrl_state_t;

    // Largest of the four phase lengths; sizes the shared phase counter.
    function automatic int max_len(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_sensor_controller_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Width-parameterised down-counter used to time each phase.
//                A load writes 'value' (phase length minus one); the counter
//                then counts down and holds at zero. 'done' is high while the
//                count is zero, i.e. during the last cycle of the phase.
//  Ports       : clk, reset (sync, active-high), load, value[WIDTH-1:0], done
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/pixel_sensor_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_sensor_controller
//  Description : Frame sequencer for the pixel array. Runs
//                ERASE -> EXPOSE -> CONVERT -> READ per frame with a one-cycle
//                GAP between analog phases, generates the digital ramp and the
//                ramp DAC enable, walks a one-hot row select, captures each
//                row and offers it downstream over valid/ready.
//  Build option: PIXEL_CTRL_FREE_RUN_EN - when defined, a frame that ends with
//                start held high rolls straight into the next frame.
//  Ports       : clk, reset (sync, active-high), start
//                erase, expose, convert, digital_ramp[PB]  - phase controls
//                read[H]                                   - row select
//                data_in[W*PB]                             - array data
//                row_data[W*PB], row_index, row_valid, row_ready - row output
//                busy, frame_done                          - status
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_sensor_controller
    import pixel_sensor_controller_pkg::*;
#(
    parameter int C_ERASE    = C_ERASE_DEF,
    parameter int C_EXPOSE   = C_EXPOSE_DEF,
    parameter int C_CONVERT  = C_CONVERT_DEF,
    parameter int C_READ_ROW = C_READ_ROW_DEF
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       start,
    output logic                                       erase,
    output logic                                       expose,
    output logic                                       convert,
    output logic [PIXEL_BITS-1:0]                      digital_ramp,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]              read,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]    data_in,
    output logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]    row_data,
    output logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]      row_index,
    output logic                                       row_valid,
    input  logic                                       row_ready,
    output logic                                       busy,
    output logic                                       frame_done
);

    localparam int c_row_w   = $clog2(PIXEL_ARRAY_HEIGHT);
    localparam int c_max_len = max_len(C_ERASE, C_EXPOSE, C_CONVERT, C_READ_ROW);
    // The counter holds length-1, so c_max_len-1 must fit.
    localparam int c_cnt_w   = (c_max_len > 1) ? $clog2(c_max_len) : 1;
    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] c_row0_sel = PIXEL_ARRAY_HEIGHT'(1);

    pixel_ctrl_state_t r_state;
    pixel_ctrl_state_t r_gap_target;
    pixel_ctrl_state_t w_next_state;
    pixel_ctrl_state_t w_next_gap_target;

    logic [PIXEL_BITS-1:0]                   r_ramp;
    logic [c_row_w-1:0]                      r_row;
    logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] r_row_data;
    logic [c_row_w-1:0]                      r_row_index;
    logic                                    r_row_valid;
    logic                                    r_frame_done;

    logic               w_timer_load;
    logic [c_cnt_w-1:0] w_timer_value;
    logic               w_timer_done;
    logic               w_transfer;
    logic               w_last_row;
    logic               w_capture;

    // ------------------------------------------------------------------
    // Shared phase counter, reloaded on every state change
    // ------------------------------------------------------------------
    phase_timer #(
        .WIDTH (c_cnt_w)
    ) u_phase_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_timer_load),
        .value (w_timer_value),
        .done  (w_timer_done)
    );

    assign w_transfer = (r_state == ST_ROW_WAIT) && r_row_valid && row_ready;
    assign w_last_row = (r_row == c_row_w'(PIXEL_ARRAY_HEIGHT - 1));
    assign w_capture  = (r_state == ST_READ_ROW) && w_timer_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_gap_target <= ST_IDLE;
        end else begin
            r_state      <= w_next_state;
            r_gap_target <= w_next_gap_target;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and counter reload
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state      = r_state;
        w_next_gap_target = r_gap_target;
        w_timer_load      = 1'b0;
        w_timer_value     = '0;

        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_ERASE;
            end
            ST_ERASE: begin
                if (w_timer_done) begin
                    w_next_state      = ST_GAP;
                    w_next_gap_target = ST_EXPOSE;
                end
            end
            ST_EXPOSE: begin
                if (w_timer_done) begin
                    w_next_state      = ST_GAP;
                    w_next_gap_target = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (w_timer_done) begin
                    w_next_state      = ST_GAP;
                    w_next_gap_target = ST_READ_ROW;
                end
            end
            ST_READ_ROW: begin
                if (w_timer_done) w_next_state = ST_ROW_WAIT;
            end
            ST_ROW_WAIT: begin
                // The frame_done cycle is spent here with row_valid low so
                // that start can be sampled alongside the pulse.
                if (r_frame_done) begin
`ifdef PIXEL_CTRL_FREE_RUN_EN
                    if (start) begin
                        w_next_state      = ST_GAP;
                        w_next_gap_target = ST_ERASE;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
`else
                    w_next_state = ST_IDLE;
`endif
                end else if (w_transfer && !w_last_row) begin
                    w_next_state = ST_READ_ROW;
                end
            end
            ST_GAP: begin
                w_next_state = r_gap_target;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase

        if (w_next_state != r_state) begin
            w_timer_load = 1'b1;
            case (w_next_state)
                ST_ERASE:    w_timer_value = c_cnt_w'(C_ERASE - 1);
                ST_EXPOSE:   w_timer_value = c_cnt_w'(C_EXPOSE - 1);
                ST_CONVERT:  w_timer_value = c_cnt_w'(C_CONVERT - 1);
                ST_READ_ROW: w_timer_value = c_cnt_w'(C_READ_ROW - 1);
                default:     w_timer_value = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ramp, row pointer and row output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ramp       <= '0;
            r_row        <= '0;
            r_row_data   <= '0;
            r_row_index  <= '0;
            r_row_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Ramp only advances while CONVERT continues, so a full-scale
            // convert leaves the phase before the counter could wrap.
            if ((r_state == ST_CONVERT) && (w_next_state == ST_CONVERT)) begin
                r_ramp <= r_ramp + 1'b1;
            end else begin
                r_ramp <= '0;
            end

            r_frame_done <= 1'b0;

            if (r_state == ST_ERASE) begin
                r_row <= '0;
            end else if (w_transfer && !w_last_row) begin
                r_row <= r_row + 1'b1;
            end

            if (w_capture) begin
                r_row_data  <= data_in;
                r_row_index <= r_row;
                r_row_valid <= 1'b1;
            end else if (w_transfer) begin
                r_row_valid  <= 1'b0;
                r_frame_done <= w_last_row;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (Moore decode of the state register)
    // ------------------------------------------------------------------
    assign erase        = (r_state == ST_ERASE);
    assign expose       = (r_state == ST_EXPOSE);
    assign convert      = (r_state == ST_CONVERT);
    assign digital_ramp = r_ramp;
    assign read         = (r_state == ST_READ_ROW) ? (c_row0_sel << r_row) : '0;
    assign row_data     = r_row_data;
    assign row_index    = r_row_index;
    assign row_valid    = r_row_valid;
    assign busy         = (r_state != ST_IDLE);
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
